// File: rtl/salamander_sndcmd_tx.sv
// salamander_sndcmd_tx
//
// Main-CPU-side transmitter for the sound command link. It latches the
// 8-bit sound code from the main CPU and raises the sound-CPU interrupt
// request as a stretched pulse of PULSE_LEN cycles. It then waits for the
// sound CPU's interrupt acknowledge, or for ACK_TIMEOUT cycles, before the
// next command may be dispatched.
//
// Build option:
//   SALAMANDER_SNDCMD_FIFO_EN  When defined, each i_INT_TRIG queues the code
//                              in a FIFO_DEPTH-entry FIFO and commands are
//                              dispatched one at a time. When undefined
//                              (direct mode), o_SNDCODE is a plain latch of
//                              the staging register and a trigger starts or
//                              restarts the pulse at once.
//
// Ports:
//   i_EMU_MCLK       system clock, rising edge
//   i_EMU_INITRST_n  asynchronous active-low reset
//   i_CODE_WR        one-cycle strobe, writes i_CODE_DIN into the staging register
//   i_CODE_DIN[7:0]  code byte from the main CPU data bus
//   i_INT_TRIG       one-cycle strobe, interrupt-trigger write
//   i_SNDCPU_ACK     level, high during the sound CPU interrupt acknowledge
//   o_SNDCODE[7:0]   code presented to the sound CPU
//   o_SNDINT         interrupt request pulse to the sound board
//   o_BUSY           FSM not idle, or FIFO non-empty
//   o_OVERFLOW       sticky: a trigger was dropped on a full FIFO
//   o_DBG_STATE[1:0] FSM state (0 IDLE, 1 LOAD, 2 PULSE, 3 WAIT_ACK)
//
// Handshake: there is no valid/ready pair here. i_CODE_WR and i_INT_TRIG
// are single-cycle strobes that are always accepted (in FIFO mode a trigger
// on a full FIFO with no pop in the same cycle is dropped and flagged);
// i_SNDCPU_ACK is a level whose rising edge is the acknowledge event.

module salamander_sndcmd_tx #(
  parameter int PULSE_LEN   = 16,
  parameter int ACK_TIMEOUT = 4096,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic       i_EMU_MCLK,
  input  logic       i_EMU_INITRST_n,
  input  logic       i_CODE_WR,
  input  logic [7:0] i_CODE_DIN,
  input  logic       i_INT_TRIG,
  input  logic       i_SNDCPU_ACK,
  output logic [7:0] o_SNDCODE,
  output logic       o_SNDINT,
  output logic       o_BUSY,
  output logic       o_OVERFLOW,
  output logic [1:0] o_DBG_STATE
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_LOAD     = 2'd1,
    ST_PULSE    = 2'd2,
    ST_WAIT_ACK = 2'd3
  } state_t;

  localparam logic [7:0]  PULSE_LAST = 8'(PULSE_LEN - 1);
  localparam logic [15:0] TMO_LAST   = 16'(ACK_TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  pulse_cnt_q;
  logic [15:0] tmo_cnt_q;
  logic [7:0]  stage_q;
  logic        ack_q;
  logic        ack_seen_q;
  logic        ack_ev;
  logic        ack_clr;
  logic        pulse_hit;
  logic        tmo_hit;
  logic        pulse_restart;

  // Parameter range checks; no hardware is generated for these.
  always_comb begin
    assert (PULSE_LEN >= 4 && PULSE_LEN <= 255);
    assert (ACK_TIMEOUT >= 1 && ACK_TIMEOUT <= 65535);
    assert (FIFO_DEPTH >= 2 && FIFO_DEPTH <= 16 && (FIFO_DEPTH & (FIFO_DEPTH - 1)) == 0);
  end

  assign ack_ev    = i_SNDCPU_ACK & ~ack_q;
  assign pulse_hit = (pulse_cnt_q == PULSE_LAST);
  assign tmo_hit   = (tmo_cnt_q == TMO_LAST);
  assign o_DBG_STATE = state_q;

`ifdef SALAMANDER_SNDCMD_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FIFO_FULL_CNT = (AW + 1)'(FIFO_DEPTH);

  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr_q, wr_ptr_q;
  logic [AW:0]   fifo_cnt_q;
  logic          fifo_full, fifo_push, fifo_pop;
  logic [7:0]    push_data;
  logic [7:0]    sndcode_q;
  logic          overflow_q;
  logic          load_go;

  assign load_go       = (state_q == ST_IDLE) && (state_d == ST_LOAD);
  assign pulse_restart = 1'b0;
  assign ack_clr       = load_go || (state_q == ST_WAIT_ACK);

  assign fifo_full = (fifo_cnt_q == FIFO_FULL_CNT);
  assign fifo_pop  = load_go;
  // A pop in the same cycle frees the slot, so a push on a full FIFO survives.
  assign fifo_push = i_INT_TRIG & (~fifo_full | fifo_pop);
  // Bypass: a code written in the trigger cycle is the one queued.
  assign push_data = i_CODE_WR ? i_CODE_DIN : stage_q;

  always_ff @(posedge i_EMU_MCLK) begin
    if (fifo_push) fifo_mem[wr_ptr_q] <= push_data;
  end

  always_ff @(posedge i_EMU_MCLK or negedge i_EMU_INITRST_n) begin
    if (!i_EMU_INITRST_n) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      sndcode_q  <= 8'h00;
      overflow_q <= 1'b0;
    end else begin
      if (fifo_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (fifo_pop) begin
        rd_ptr_q  <= rd_ptr_q + AW'(1);
        sndcode_q <= fifo_mem[rd_ptr_q];
      end
      if (fifo_push && !fifo_pop)      fifo_cnt_q <= fifo_cnt_q + (AW + 1)'(1);
      else if (!fifo_push && fifo_pop) fifo_cnt_q <= fifo_cnt_q - (AW + 1)'(1);
      if (i_INT_TRIG && fifo_full && !fifo_pop) overflow_q <= 1'b1;
    end
  end

  assign o_SNDCODE  = sndcode_q;
  assign o_OVERFLOW = overflow_q;
`else
  logic trig_go;

  // A trigger is taken in every reachable state and always lands in PULSE.
  assign trig_go       = i_INT_TRIG && (state_d == ST_PULSE);
  assign pulse_restart = i_INT_TRIG && (state_q == ST_PULSE);
  assign ack_clr       = trig_go || (state_q == ST_WAIT_ACK);

  // Direct mode behaves as a transparent-after-write latch.
  assign o_SNDCODE  = stage_q;
  assign o_OVERFLOW = 1'b0;
`endif

  // State register and datapath registers.
  always_ff @(posedge i_EMU_MCLK or negedge i_EMU_INITRST_n) begin
    if (!i_EMU_INITRST_n) begin
      state_q     <= ST_IDLE;
      pulse_cnt_q <= 8'd0;
      tmo_cnt_q   <= 16'd0;
      stage_q     <= 8'h00;
      ack_q       <= 1'b0;
      ack_seen_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_q   <= i_SNDCPU_ACK;
      if (i_CODE_WR) stage_q <= i_CODE_DIN;

      // Counts cycles already spent in PULSE; zero on entry and on restart.
      if (state_q == ST_PULSE && state_d == ST_PULSE && !pulse_restart)
        pulse_cnt_q <= pulse_cnt_q + 8'd1;
      else
        pulse_cnt_q <= 8'd0;

      // Counts cycles already spent in WAIT_ACK; zero on entry.
      if (state_q == ST_WAIT_ACK && state_d == ST_WAIT_ACK)
        tmo_cnt_q <= tmo_cnt_q + 16'd1;
      else
        tmo_cnt_q <= 16'd0;

      // An acknowledge that arrives while the pulse is still being stretched
      // is remembered so WAIT_ACK can release on its first cycle. Clearing
      // wins over setting: an ack coinciding with a new command belongs to
      // the old one.
      if (ack_clr)                             ack_seen_q <= 1'b0;
      else if (state_q == ST_PULSE && ack_ev)  ack_seen_q <= 1'b1;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
`ifdef SALAMANDER_SNDCMD_FIFO_EN
        if (fifo_cnt_q != '0) state_d = ST_LOAD;
`else
        if (i_INT_TRIG) state_d = ST_PULSE;
`endif
      end
      ST_LOAD: state_d = ST_PULSE;
      ST_PULSE: begin
        if (pulse_hit && !pulse_restart) state_d = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (ack_ev || ack_seen_q || tmo_hit) state_d = ST_IDLE;
`ifndef SALAMANDER_SNDCMD_FIFO_EN
        if (i_INT_TRIG) state_d = ST_PULSE;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decode registered state only.
  always_comb begin
    o_SNDINT = (state_q == ST_PULSE);
`ifdef SALAMANDER_SNDCMD_FIFO_EN
    o_BUSY   = (state_q != ST_IDLE) || (fifo_cnt_q != '0);
`else
    o_BUSY   = (state_q != ST_IDLE);
`endif
  end

endmodule

// File: tb/tb_salamander_sndcmd_tx.sv
// Testbench for salamander_sndcmd_tx (default parameters). Works in either
// build; the FIFO-specific sequences are compiled in with
// SALAMANDER_SNDCMD_FIFO_EN, the direct-mode ones otherwise.
`timescale 1ns/1ps

module tb_salamander_sndcmd_tx;

  localparam int PULSE_LEN   = 16;
  localparam int ACK_TIMEOUT = 4096;
  localparam int FIFO_DEPTH  = 4;
`ifdef SALAMANDER_SNDCMD_FIFO_EN
  localparam int LAT = 3;   // trigger to first o_SNDINT cycle
`else
  localparam int LAT = 1;
`endif

  // ---------------- clock / reset ----------------
  logic       mclk = 1'b0;
  logic       rst_n;
  logic       code_wr;
  logic [7:0] code_din;
  logic       int_trig;
  logic       snd_ack;
  logic [7:0] sndcode;
  logic       sndint;
  logic       busy;
  logic       overflow;
  logic [1:0] dbg_state;

  always #5 mclk = ~mclk;

  salamander_sndcmd_tx #(
    .PULSE_LEN(PULSE_LEN), .ACK_TIMEOUT(ACK_TIMEOUT), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .i_EMU_MCLK(mclk),
    .i_EMU_INITRST_n(rst_n),
    .i_CODE_WR(code_wr),
    .i_CODE_DIN(code_din),
    .i_INT_TRIG(int_trig),
    .i_SNDCPU_ACK(snd_ack),
    .o_SNDCODE(sndcode),
    .o_SNDINT(sndint),
    .o_BUSY(busy),
    .o_OVERFLOW(overflow),
    .o_DBG_STATE(dbg_state)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    code_wr = 1'b0; code_din = 8'h00; int_trig = 1'b0; snd_ack = 1'b0;
    repeat (2) @(negedge mclk);
    rst_n = 1'b1;
    @(negedge mclk);
  endtask

  // ---------------- reference model ----------------
  // Tracks the command as "cycles of pulse left" and "cycles of wait left";
  // state after each clock edge is derived from those counts.
  logic [7:0] m_code, m_stage;
  logic [7:0] m_q[$];
  bit         m_load, m_early, m_ovf, m_prev_ack;
  int         m_pulse_left, m_wait_left;

  function automatic void model_reset();
    m_code = 8'h00; m_stage = 8'h00; m_q.delete();
    m_load = 0; m_early = 0; m_ovf = 0; m_prev_ack = 0;
    m_pulse_left = 0; m_wait_left = 0;
  endfunction

  function automatic bit m_int();
    return m_pulse_left > 0;
  endfunction

  function automatic bit m_busy();
    return m_load || m_pulse_left > 0 || m_wait_left > 0 || m_q.size() > 0;
  endfunction

  function automatic void model_advance(input bit ack_ev);
    if (m_pulse_left > 0) begin
      if (ack_ev) m_early = 1;
      m_pulse_left--;
      if (m_pulse_left == 0) m_wait_left = ACK_TIMEOUT;
    end else if (m_wait_left > 0) begin
      if (ack_ev || m_early) begin m_wait_left = 0; m_early = 0; end
      else m_wait_left--;
    end
  endfunction

  function automatic void model_step(input bit wr, input logic [7:0] din, input bit trig, input bit ack);
    bit ack_ev;
    ack_ev = ack && !m_prev_ack;
    m_prev_ack = ack;
`ifdef SALAMANDER_SNDCMD_FIFO_EN
    begin
      bit idle, pop, full;
      logic [7:0] pdata;
      idle  = !m_load && m_pulse_left == 0 && m_wait_left == 0;
      pop   = idle && m_q.size() > 0;
      full  = (m_q.size() == FIFO_DEPTH);
      pdata = wr ? din : m_stage;
      if (wr) m_stage = din;
      if (pop) begin m_code = m_q.pop_front(); m_load = 1; m_early = 0; end
      else if (m_load) begin m_load = 0; m_pulse_left = PULSE_LEN; end
      else model_advance(ack_ev);
      if (trig) begin
        if (full && !pop) m_ovf = 1;
        else m_q.push_back(pdata);
      end
    end
`else
    if (wr) m_code = din;
    if (trig) begin m_pulse_left = PULSE_LEN; m_wait_left = 0; m_early = 0; end
    else model_advance(ack_ev);
`endif
  endfunction

  // ---------------- driver tasks ----------------
  // Writes a code, triggers, then follows the command until o_BUSY drops.
  // ack_at is the pulse cycle (1 = first o_SNDINT cycle) at which the ack
  // level rises; 0 means never.
  task automatic run_cmd(input logic [7:0] code, input int ack_at,
                         output int n_int, output int n_busy,
                         output int first_int, output logic [7:0] code_at_int);
    code_wr = 1'b1; code_din = code;
    @(negedge mclk);
    code_wr = 1'b0;
`ifndef SALAMANDER_SNDCMD_FIFO_EN
    check("code_after_wr", sndcode, code);
`endif
    int_trig = 1'b1;
    @(negedge mclk);
    int_trig = 1'b0;
    n_int = 0; n_busy = 0; first_int = 0; code_at_int = 8'h00;
    for (int t = 1; t <= 20000; t++) begin
      if (sndint) begin
        n_int++;
        if (first_int == 0) begin first_int = t; code_at_int = sndcode; end
      end
      if (busy) n_busy++;
      else break;
      snd_ack = (ack_at != 0) && (t >= ack_at + LAT - 1);
      @(negedge mclk);
    end
    check("cmd_done_busy", busy, 1'b0);
    snd_ack = 1'b0;
    repeat (3) @(negedge mclk);
  endtask

`ifndef SALAMANDER_SNDCMD_FIFO_EN
  // Direct mode: optional retrigger at cycle retrig_at and optional code write
  // at cycle wr_at while the command is in flight.
  task automatic run_direct(input int retrig_at, input int ack_at, input int wr_at,
                            input logic [7:0] wr_code, output int n_int, output int n_busy);
    code_wr = 1'b1; code_din = 8'h11;
    @(negedge mclk);
    code_wr = 1'b0; int_trig = 1'b1;
    @(negedge mclk);
    int_trig = 1'b0;
    n_int = 0; n_busy = 0;
    for (int t = 1; t <= 20000; t++) begin
      if (sndint) n_int++;
      if (busy) n_busy++;
      else break;
      if (wr_at != 0 && t == wr_at + 1) check("latch_in_flight", sndcode, wr_code);
      int_trig = (t == retrig_at);
      code_wr  = (t == wr_at);
      code_din = wr_code;
      snd_ack  = (ack_at != 0) && (t >= ack_at);
      @(negedge mclk);
    end
    int_trig = 1'b0; code_wr = 1'b0; snd_ack = 1'b0;
    check("direct_done_busy", busy, 1'b0);
    repeat (3) @(negedge mclk);
  endtask
`endif

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0] code;
    int         ack_at;
    int         exp_busy;   // busy cycles measured from the first pulse cycle
  } vec_t;

  vec_t vecs[7];

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    n_errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // ---------------- main sequence ----------------
  initial begin
    int n_int, n_busy, first_int, cnt;
    logic [7:0] code_at_int;
    logic [7:0] exp_q[$];
    bit prev_int;

    vecs[0] = '{8'h2A, 30, 30};
    vecs[1] = '{8'h55, 5, 17};
    vecs[2] = '{8'h81, 16, 17};
    vecs[3] = '{8'hC3, 17, 17};
    vecs[4] = '{8'h07, 1, 17};
    vecs[5] = '{8'hFF, 100, 100};
    vecs[6] = '{8'h5A, 18, 18};

    // Reset values, while reset is held.
    rst_n = 1'b0;
    code_wr = 1'b0; code_din = 8'h00; int_trig = 1'b0; snd_ack = 1'b0;
    repeat (2) @(negedge mclk);
    check("rst_code", sndcode, 8'h00);
    check("rst_int", sndint, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_ovf", overflow, 1'b0);
    check("rst_dbg_state", dbg_state, 2'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge mclk);
    check("post_rst_busy", busy, 1'b0);
    check("post_rst_int", sndint, 1'b0);

    // Table-driven single commands.
    for (int i = 0; i < 7; i++) begin
      run_cmd(vecs[i].code, vecs[i].ack_at, n_int, n_busy, first_int, code_at_int);
      check("vec_pulse_len", n_int, PULSE_LEN);
      check("vec_busy_len", n_busy, vecs[i].exp_busy + LAT - 1);
      check("vec_latency", first_int, LAT);
      check("vec_code", code_at_int, vecs[i].code);
    end

    // Timeout: ack never comes.
    run_cmd(8'h3C, 0, n_int, n_busy, first_int, code_at_int);
    check("tmo_pulse_len", n_int, PULSE_LEN);
    check("tmo_busy_len", n_busy, PULSE_LEN + ACK_TIMEOUT + LAT - 1);
    cnt = 0;
    for (int t = 0; t < 20; t++) begin
      if (sndint) cnt++;
      @(negedge mclk);
    end
    check("tmo_no_repulse", cnt, 0);

`ifndef SALAMANDER_SNDCMD_FIFO_EN
    // Retrigger during PULSE at cycle 5 restarts the count: 5 + 16 cycles.
    // A code written at cycle 8 is visible at cycle 9.
    run_direct(5, 25, 8, 8'h22, n_int, n_busy);
    check("restart_pulse_len", n_int, 5 + PULSE_LEN);
    check("restart_busy_len", n_busy, 25);
    // Retrigger in WAIT_ACK (cycle 20) goes straight back to PULSE.
    run_direct(20, 40, 0, 8'h00, n_int, n_busy);
    check("wait_retrig_pulse_len", n_int, 2 * PULSE_LEN);
    check("wait_retrig_busy_len", n_busy, 40);
    check("direct_ovf", overflow, 1'b0);
`else
    // Three back-to-back commands, each acknowledged; order must hold.
    exp_q.delete();
    prev_int = 0;
    cnt = 0;
    for (int t = 0; t < 600; t++) begin
      if (sndint && !prev_int) begin
        cnt++;
        if (exp_q.size() == 0) check("fifo_order_extra", sndcode, 8'hEE);
        else check("fifo_order_code", sndcode, exp_q.pop_front());
      end
      prev_int = sndint;
      if (t > 3 && !busy) break;
      code_wr  = (t < 3);
      int_trig = (t < 3);
      code_din = 8'(t + 1);
      if (t < 3) exp_q.push_back(8'(t + 1));
      snd_ack  = sndint;
      @(negedge mclk);
    end
    code_wr = 1'b0; int_trig = 1'b0; snd_ack = 1'b0;
    check("fifo_order_pulses", cnt, 3);
    check("fifo_order_left", exp_q.size(), 0);
    check("fifo_order_idle", busy, 1'b0);
    repeat (3) @(negedge mclk);

    // Six triggers with no gaps: the first pops to LOAD, four fill the FIFO,
    // the sixth is dropped and must never be presented.
    exp_q.delete();
    prev_int = 0;
    for (int t = 0; t < 600; t++) begin
      if (sndint && !prev_int) begin
        if (exp_q.size() == 0) check("ovf_extra_code", sndcode, 8'hEE);
        else check("ovf_code", sndcode, exp_q.pop_front());
      end
      prev_int = sndint;
      if (t == 5) check("ovf_before_6th", overflow, 1'b0);
      if (t == 6) check("ovf_after_6th", overflow, 1'b1);
      if (t > 6 && !busy) break;
      code_wr  = (t < 6);
      int_trig = (t < 6);
      code_din = 8'(8'h10 + t);
      if (t < 5) exp_q.push_back(8'(8'h10 + t));
      snd_ack  = sndint;
      @(negedge mclk);
    end
    code_wr = 1'b0; int_trig = 1'b0; snd_ack = 1'b0;
    check("ovf_drained", exp_q.size(), 0);
    check("ovf_sticky", overflow, 1'b1);
    check("ovf_idle", busy, 1'b0);
`endif

    // Reset in the middle of a pulse with further commands queued.
    for (int t = 0; t < 3; t++) begin
      code_wr = 1'b1; int_trig = 1'b1; code_din = 8'(8'hA0 + t);
      @(negedge mclk);
    end
    code_wr = 1'b0; int_trig = 1'b0;
    cnt = 0;
    while (!sndint && cnt < 50) begin cnt++; @(negedge mclk); end
    check("midrst_pulse_seen", sndint, 1'b1);
    @(posedge mclk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_code", sndcode, 8'h00);
    check("midrst_int", sndint, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_ovf", overflow, 1'b0);
    repeat (2) @(negedge mclk);
    rst_n = 1'b1;
    cnt = 0;
    for (int t = 0; t < 60; t++) begin
      @(negedge mclk);
      if (sndint || busy) cnt++;
    end
    check("midrst_quiet", cnt, 0);

    // Randomized run against the reference model.
    reset_dut();
    model_reset();
    for (int i = 0; i < 3000; i++) begin
      check("rnd_code", sndcode, m_code);
      check("rnd_int", sndint, m_int());
      check("rnd_busy", busy, m_busy());
      check("rnd_ovf", overflow, m_ovf);
      code_wr  = ($urandom_range(0, 3) == 0);
      code_din = 8'($urandom_range(0, 255));
      int_trig = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 5) == 0) snd_ack = ~snd_ack;
      model_step(code_wr, code_din, int_trig, snd_ack);
      @(negedge mclk);
    end
    code_wr = 1'b0; int_trig = 1'b0; snd_ack = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
